// File: rtl/fifo_write_arbiter.sv
// Round-robin write-side arbiter: shares one FIFO push port among nreq producers,
// caps each ownership at burst words and sequences single-cycle FIFO flushes.
module fifo_write_arbiter #(
    parameter int width = 16,
    parameter int nreq  = 4,
    parameter int burst = 4,
    localparam int ow   = (nreq > 1) ? $clog2(nreq) : 1,
    localparam int cw   = $clog2(burst + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [nreq-1:0]       req,
    input  logic [nreq*width-1:0] req_data,
    output logic [nreq-1:0]       ack,
    input  logic                  flush_req,
    input  logic                  fifo_full,
    output logic                  fifo_addq,
    output logic [width-1:0]      fifo_indata,
    output logic                  fifo_flush,
    output logic                  owner_valid,
    output logic [ow-1:0]         owner
);

    typedef enum logic [1:0] {ST_IDLE, ST_OWN, ST_FLUSH} state_t;

    localparam logic [ow-1:0] last_idx  = ow'(nreq - 1);
    localparam logic [cw-1:0] last_beat = cw'(burst - 1);

    state_t        state, state_d;
    logic [ow-1:0] owner_d, rr_ptr, rr_ptr_d, rr_pick, owner_inc;
    logic [cw-1:0] burst_cnt, burst_cnt_d;
    logic          grant;
    int            k;

    // Scan offsets from far to near so the requester closest to rr_ptr wins.
    always_comb begin
        rr_pick = rr_ptr;
        k       = 0;
        for (int i = nreq - 1; i >= 0; i--) begin
            k = int'(rr_ptr) + i;
            if (k >= nreq) k = k - nreq;
            if (req[k]) rr_pick = ow'(k);
        end
    end

    assign owner_inc   = (owner == last_idx) ? '0 : owner + 1'b1;
    assign fifo_indata = req_data[owner * width +: width];
    assign fifo_addq   = grant;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d     = state;
        owner_d     = owner;
        rr_ptr_d    = rr_ptr;
        burst_cnt_d = burst_cnt;
        ack         = '0;
        grant       = 1'b0;
        fifo_flush  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (flush_req) begin
                    state_d = ST_FLUSH;
                end else if (|req) begin
                    state_d     = ST_OWN;
                    owner_d     = rr_pick;
                    burst_cnt_d = '0;
                end
            end
            ST_OWN: begin
                grant      = req[owner] & ~fifo_full & ~flush_req;
                ack[owner] = grant;
                if (grant) burst_cnt_d = burst_cnt + 1'b1;
                // A full FIFO only stalls; release needs flush, a dropped req or the last beat.
                if (flush_req) begin
                    state_d  = ST_FLUSH;
                    rr_ptr_d = owner_inc;
                end else if (!req[owner] || (grant && burst_cnt == last_beat)) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = owner_inc;
                end
            end
            ST_FLUSH: begin
                fifo_flush = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Reset wins over every input, including the combinational handshake.
        if (reset) begin
            ack        = '0;
            grant      = 1'b0;
            fifo_flush = 1'b0;
        end
    end

    // NOTE: state flops use non-blocking assignments so each one samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            owner       <= '0;
            rr_ptr      <= '0;
            burst_cnt   <= '0;
            owner_valid <= 1'b0;
        end else begin
            state       <= state_d;
            owner       <= owner_d;
            rr_ptr      <= rr_ptr_d;
            burst_cnt   <= burst_cnt_d;
            owner_valid <= (state_d == ST_OWN);
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: producer models plus a scoreboard
// of expected FIFO writes, and per-scenario cycle tables for handshake/ownership.
module tb_fifo_write_arbiter;

    localparam int W     = 16;
    localparam int NREQ  = 4;
    localparam int BURST = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [NREQ-1:0] req;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0] ack;
    logic            flush_req;
    logic            fifo_full;
    logic            fifo_addq;
    logic [W-1:0]    fifo_indata;
    logic            fifo_flush;
    logic            owner_valid;
    logic [1:0]      owner;

    always #5 clk = ~clk;

    fifo_write_arbiter #(.width(W), .nreq(NREQ), .burst(BURST)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .flush_req  (flush_req),
        .fifo_full  (fifo_full),
        .fifo_addq  (fifo_addq),
        .fifo_indata(fifo_indata),
        .fifo_flush (fifo_flush),
        .owner_valid(owner_valid),
        .owner      (owner)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [NREQ-1:0] want;
    logic [NREQ-1:0] ack_seen = '0;
    int cnt  [NREQ];
    int left [NREQ];

    typedef struct {
        int           idx;
        logic [W-1:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    function automatic logic [W-1:0] word_of(input int i, input int n);
        return {4'(i), 12'(n)};
    endfunction

    task automatic push_words(input int i, input int first, input int n);
        exp_t e;
        for (int j = 0; j < n; j++) begin
            e.idx  = i;
            e.data = word_of(i, first + j);
            sb.push_back(e);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc();
        reset = 1'b1; want = '0; flush_req = 1'b0; fifo_full = 1'b0;
        for (int i = 0; i < NREQ; i++) left[i] = 1000;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    // Producers: advance to the next word after each consumed one.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < NREQ; i++) begin
                if (ack_seen[i]) begin
                    cnt[i]++;
                    left[i]--;
                end
                req[i] = want[i] && (left[i] != 0);
                req_data[i*W +: W] = word_of(i, cnt[i]);
            end
        end
    end

    // Scoreboard: every FIFO push must match the next expected word and requester.
    initial begin
        forever begin
            @(negedge clk);
            ack_seen = ack;
            if (fifo_addq || fifo_flush) begin
                n_checks++;
                if ((fifo_addq && fifo_flush) !== 1'b0) begin
                    n_fail++;
                    $display("FAIL no_overlap addq=%b flush=%b required not both", fifo_addq, fifo_flush);
                end
            end
            if (fifo_addq === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected_write ack=%b data=%h required no write", ack, fifo_indata);
                end else begin
                    mon_e = sb.pop_front();
                    if ({ack, fifo_indata} !== {NREQ'(1) << mon_e.idx, mon_e.data}) begin
                        n_fail++;
                        $display("FAIL sb_write ack=%b data=%h required ack=%b data=%h",
                                 ack, fifo_indata, NREQ'(1) << mon_e.idx, mon_e.data);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        logic [5:0] tab [9];
        tab = '{6'b000000, 6'b010001, 6'b010001, 6'b010001, 6'b010001,
                6'b000000, 6'b010010, 6'b010000, 6'b000000};
        push_words(0, cnt[0], 4);
        push_words(1, cnt[1], 1);
        repeat (3) begin
            cyc();
            @(negedge clk);
            n_checks++;
            if ({fifo_flush, owner_valid, ack, fifo_addq, owner} !== 9'b0) begin
                n_fail++;
                $display("FAIL reset_outputs flush=%b valid=%b ack=%b addq=%b owner=%0d required all 0",
                         fifo_flush, owner_valid, ack, fifo_addq, owner);
            end
        end
        cyc();
        reset = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) cyc();
            if (k == 7) want = '0;
            @(negedge clk);
            n_checks++;
            if ({fifo_flush, owner_valid, ack} !== tab[k]) begin
                n_fail++;
                $display("FAIL reset_first_grant k=%0d got=%b required=%b", k, {fifo_flush, owner_valid, ack}, tab[k]);
            end
            if (tab[k][4]) begin
                n_checks++;
                if (owner !== ((k < 5) ? 2'd0 : 2'd1)) begin
                    n_fail++;
                    $display("FAIL reset_owner k=%0d got=%0d required=%0d", k, owner, (k < 5) ? 0 : 1);
                end
            end
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL reset_drain pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_round_robin();
        int idx;
        logic exp_v;
        do_reset();
        push_words(0, cnt[0], 4);
        push_words(3, cnt[3], 4);
        push_words(0, cnt[0] + 4, 4);
        push_words(3, cnt[3] + 4, 4);
        want = 4'b1001;
        for (int k = 0; k < 22; k++) begin
            if (k > 0) cyc();
            if (k == 20) want = '0;
            @(negedge clk);
            exp_v = (k < 20) && (k % 5 != 0);
            idx   = ((k / 5) % 2 == 0) ? 0 : 3;
            n_checks++;
            if ({owner_valid, ack} !== {exp_v, exp_v ? NREQ'(1) << idx : NREQ'(0)}) begin
                n_fail++;
                $display("FAIL rr_wrap k=%0d valid=%b ack=%b required valid=%b owner=%0d", k, owner_valid, ack, exp_v, idx);
            end
            if (exp_v) begin
                n_checks++;
                if (owner !== 2'(idx)) begin
                    n_fail++;
                    $display("FAIL rr_owner k=%0d got=%0d required=%0d", k, owner, idx);
                end
            end
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL rr_drain pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_full_stall();
        logic exp_v, exp_a;
        do_reset();
        push_words(2, cnt[2], 4);
        want = 4'b0100;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) cyc();
            fifo_full = (k >= 3) && (k <= 7);
            if (k == 10) want = '0;
            @(negedge clk);
            exp_v = (k >= 1) && (k <= 9);
            exp_a = (k == 1) || (k == 2) || (k == 8) || (k == 9);
            n_checks++;
            if ({owner_valid, ack} !== {exp_v, exp_a ? 4'b0100 : 4'b0000}) begin
                n_fail++;
                $display("FAIL full_stall k=%0d valid=%b ack=%b required valid=%b ack=%b",
                         k, owner_valid, ack, exp_v, exp_a ? 4'b0100 : 4'b0000);
            end
            if (exp_v) begin
                n_checks++;
                if (owner !== 2'd2) begin
                    n_fail++;
                    $display("FAIL full_owner k=%0d got=%0d required=2", k, owner);
                end
            end
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL full_drain pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_early_release();
        logic [5:0] tab [7];
        int own [7];
        tab = '{6'b000000, 6'b010010, 6'b010000, 6'b000000, 6'b010100, 6'b010000, 6'b000000};
        own = '{0, 1, 1, 0, 2, 2, 0};
        do_reset();
        push_words(1, cnt[1], 1);
        push_words(2, cnt[2], 1);
        want = 4'b0010;
        left[1] = 1;
        for (int k = 0; k < 7; k++) begin
            if (k > 0) cyc();
            if (k == 2) want = 4'b0101;
            if (k == 5) want = '0;
            @(negedge clk);
            n_checks++;
            if ({fifo_flush, owner_valid, ack} !== tab[k]) begin
                n_fail++;
                $display("FAIL early_release k=%0d got=%b required=%b", k, {fifo_flush, owner_valid, ack}, tab[k]);
            end
            if (tab[k][4]) begin
                n_checks++;
                if (owner !== 2'(own[k])) begin
                    n_fail++;
                    $display("FAIL early_owner k=%0d got=%0d required=%0d", k, owner, own[k]);
                end
            end
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL early_drain pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_flush_mid_burst();
        logic [5:0] tab [8];
        int own [8];
        tab = '{6'b000000, 6'b010100, 6'b010000, 6'b100000,
                6'b000000, 6'b011000, 6'b010000, 6'b000000};
        own = '{0, 2, 2, 0, 0, 3, 3, 0};
        do_reset();
        push_words(2, cnt[2], 1);
        push_words(3, cnt[3], 1);
        want = 4'b1100;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) cyc();
            if (k == 2) flush_req = 1'b1;
            if (k == 3) flush_req = 1'b0;
            if (k == 6) want = '0;
            @(negedge clk);
            n_checks++;
            if ({fifo_flush, owner_valid, ack} !== tab[k]) begin
                n_fail++;
                $display("FAIL flush_mid k=%0d got=%b required=%b", k, {fifo_flush, owner_valid, ack}, tab[k]);
            end
            if (tab[k][4]) begin
                n_checks++;
                if (owner !== 2'(own[k])) begin
                    n_fail++;
                    $display("FAIL flush_owner k=%0d got=%0d required=%0d", k, owner, own[k]);
                end
            end
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL flush_drain pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_flush_repeat();
        logic [5:0] tab [8];
        tab = '{6'b000000, 6'b100000, 6'b000000, 6'b100000,
                6'b000000, 6'b010001, 6'b010000, 6'b000000};
        do_reset();
        push_words(0, cnt[0], 1);
        want = 4'b0001;
        flush_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) cyc();
            if (k == 3) flush_req = 1'b0;
            if (k == 6) want = '0;
            @(negedge clk);
            n_checks++;
            if ({fifo_flush, owner_valid, ack} !== tab[k]) begin
                n_fail++;
                $display("FAIL flush_repeat k=%0d got=%b required=%b", k, {fifo_flush, owner_valid, ack}, tab[k]);
            end
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL flush_rep_drain pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset_mid_op();
        logic [5:0] tab [12];
        int own [12];
        tab = '{6'b000000, 6'b010010, 6'b010010, 6'b010010, 6'b010010, 6'b000000,
                6'b011000, 6'b010000, 6'b000000, 6'b010001, 6'b010000, 6'b000000};
        own = '{0, 1, 1, 1, 1, 1, 3, 3, 0, 0, 0, 0};
        do_reset();
        push_words(1, cnt[1], 4);
        push_words(3, cnt[3], 1);
        push_words(0, cnt[0], 1);
        want = 4'b1010;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) cyc();
            if (k == 7) begin
                reset = 1'b1;
                want  = 4'b1001;
            end
            if (k == 8) reset = 1'b0;
            if (k == 10) want = '0;
            @(negedge clk);
            n_checks++;
            if ({fifo_flush, owner_valid, ack} !== tab[k]) begin
                n_fail++;
                $display("FAIL reset_mid k=%0d got=%b required=%b", k, {fifo_flush, owner_valid, ack}, tab[k]);
            end
            n_checks++;
            if (owner !== 2'(own[k])) begin
                n_fail++;
                $display("FAIL reset_mid_owner k=%0d got=%0d required=%0d", k, owner, own[k]);
            end
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL reset_mid_drain pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        flush_req = 1'b0;
        fifo_full = 1'b0;
        want      = 4'b1111;
        req       = '0;
        req_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cnt[i]  = 0;
            left[i] = 1000;
        end

        test_reset();
        test_round_robin();
        test_full_stall();
        test_early_release();
        test_flush_mid_burst();
        test_flush_repeat();
        test_reset_mid_op();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
